// File: rtl/tdm_demux_if.sv
// Link-side bundle for the TDM demultiplexer: serial input beat plus the parallel per-channel outputs.
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  logic              in_valid;
  logic              in_sof;
  logic [W-1:0]      in_data;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, frame_done, sync_err, locked
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// Locks to a TDM frame (ch0 flagged by in_sof) and fans each sample out to a held per-channel slot.
// Latency: 1 cycle from accepted beat to out_data/out_valid/frame_done/sync_err.
// Backpressure: none; every in_valid beat is consumed or discarded in its own cycle.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);
  localparam int             CW   = $clog2(N_CH);
  localparam logic [CW-1:0]  LAST = CW'(N_CH - 1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [CW-1:0]     slot;
  logic              wr;
  logic              err;
  logic [N_CH*W-1:0] data_q;
  logic [N_CH-1:0]   strobe_q;
  logic              done_q;
  logic              err_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    slot    = ch_q;
    wr      = 1'b0;
    err     = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            wr      = 1'b1;
            slot    = '0;
            ch_d    = CW'(1);
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (bus.in_sof) begin
            // An early SOF restarts the frame; the truncated one never reports done.
            wr   = 1'b1;
            slot = '0;
            ch_d = CW'(1);
            err  = (ch_q != '0);
          end else if (ch_q != '0) begin
            wr   = 1'b1;
            ch_d = (ch_q == LAST) ? '0 : ch_q + CW'(1);
          end else begin
            err     = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      ch_q     <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      err_q   <= err;
      done_q  <= wr && (slot == LAST);
      for (int c = 0; c < N_CH; c++) begin
        strobe_q[c] <= wr && (slot == CW'(c));
        if (wr && (slot == CW'(c)))
          data_q[c*W +: W] <= bus.in_data;
      end
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_valid  = strobe_q;
  assign bus.frame_done = done_q;
  assign bus.sync_err   = err_q;
  assign bus.locked     = (state_q == LOCK);
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frame scenarios plus randomized beats against a frame-level model.
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();
  tdm_demux #(.N_CH(N_CH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Frame-level model: lock flag, index of the next expected channel, held slots.
  logic              m_locked;
  int                m_next;
  logic [W-1:0]      m_slot [N_CH];
  logic [N_CH-1:0]   exp_strobe;
  logic              exp_fd;
  logic              exp_err;

  function automatic logic [N_CH*W-1:0] m_pack();
    logic [N_CH*W-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c*W +: W] = m_slot[c];
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_next = 0;
    for (int c = 0; c < N_CH; c++) m_slot[c] = '0;
    exp_strobe = '0; exp_fd = 1'b0; exp_err = 1'b0;
  endtask

  task automatic m_write(input int i, input logic [W-1:0] d);
    m_slot[i] = d;
    exp_strobe[i] = 1'b1;
    exp_fd = (i == N_CH - 1);
  endtask

  task automatic model_beat(input logic v, input logic s, input logic [W-1:0] d);
    exp_strobe = '0; exp_fd = 1'b0; exp_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin m_write(0, d); m_locked = 1'b1; m_next = 1; end
      end else if (s) begin
        exp_err = (m_next != 0);
        m_write(0, d); m_next = 1;
      end else if (m_next != 0) begin
        m_write(m_next, d); m_next = (m_next + 1) % N_CH;
      end else begin
        exp_err = 1'b1; m_locked = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    bus.in_valid = v; bus.in_sof = s; bus.in_data = d;
    @(posedge clk); #1;
    model_beat(v, s, d);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    rst = 1'b1; model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_data = 8'h5A;
    rst = 1'b1; model_reset();
    @(posedge clk); #1;
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset out_data got %h exp 0", bus.out_data); end
    checks++; if (bus.out_valid !== '0) begin errors++; $display("FAIL reset out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b exp 0", bus.frame_done); end
    checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset sync_err got %b exp 0", bus.sync_err); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset locked got %b exp 0", bus.locked); end
    do_reset();
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, dat[i]);
      checks++; if (bus.out_data !== m_pack()) begin errors++; $display("FAIL basic out_data got %h exp %h", bus.out_data, m_pack()); end
      checks++; if (bus.out_valid !== 4'(1 << i)) begin errors++; $display("FAIL basic out_valid beat %0d got %b exp %b", i, bus.out_valid, 4'(1 << i)); end
      checks++; if (bus.frame_done !== (i == 3)) begin errors++; $display("FAIL basic frame_done beat %0d got %b", i, bus.frame_done); end
      checks++; if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL basic sync_err got %b exp 0", bus.sync_err); end
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL basic locked got %b exp 1", bus.locked); end
    end
    checks++; if (bus.out_data !== 32'hD3C2B1A0) begin errors++; $display("FAIL basic final out_data got %h exp d3c2b1a0", bus.out_data); end
  endtask

  task automatic test_hunt_discard();
    logic [W-1:0] dat [6] = '{8'h11, 8'h22, 8'h44, 8'h55, 8'h66, 8'h77};
    int n_err = 0, n_fd = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i == 2, dat[i]);
      n_err += int'(bus.sync_err); n_fd += int'(bus.frame_done);
      checks++; if (bus.out_data !== m_pack()) begin errors++; $display("FAIL hunt out_data got %h exp %h", bus.out_data, m_pack()); end
      checks++; if (bus.out_valid !== exp_strobe) begin errors++; $display("FAIL hunt out_valid got %b exp %b", bus.out_valid, exp_strobe); end
      checks++; if (bus.locked !== (i >= 2)) begin errors++; $display("FAIL hunt locked beat %0d got %b", i, bus.locked); end
    end
    checks++; if (n_err != 0) begin errors++; $display("FAIL hunt sync_err count got %0d exp 0", n_err); end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL hunt frame_done count got %0d exp 1", n_fd); end
    checks++; if (bus.out_data !== 32'h77665544) begin errors++; $display("FAIL hunt final out_data got %h exp 77665544", bus.out_data); end
  endtask

  task automatic test_early_sof();
    logic [W-1:0] dat [6] = '{8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic         sof [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int n_fd = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, sof[i], dat[i]);
      n_fd += int'(bus.frame_done);
      checks++; if (bus.sync_err !== (i == 2)) begin errors++; $display("FAIL early_sof sync_err beat %0d got %b", i, bus.sync_err); end
      checks++; if (bus.out_valid !== exp_strobe) begin errors++; $display("FAIL early_sof out_valid got %b exp %b", bus.out_valid, exp_strobe); end
      checks++; if (bus.out_data !== m_pack()) begin errors++; $display("FAIL early_sof out_data got %h exp %h", bus.out_data, m_pack()); end
    end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL early_sof frame_done count got %0d exp 1", n_fd); end
    checks++; if (bus.out_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL early_sof final out_data got %h exp ddccbbaa", bus.out_data); end
  endtask

  task automatic test_missing_sof();
    step(1'b1, 1'b0, 8'h99);
    checks++; if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL missing_sof sync_err got %b exp 1", bus.sync_err); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL missing_sof locked got %b exp 0", bus.locked); end
    checks++; if (bus.out_valid !== '0) begin errors++; $display("FAIL missing_sof out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL missing_sof out_data got %h exp ddccbbaa", bus.out_data); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, 8'(16 * (i + 1)));
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock locked got %b exp 1", bus.locked); end
      checks++; if (bus.out_valid !== exp_strobe) begin errors++; $display("FAIL relock out_valid got %b exp %b", bus.out_valid, exp_strobe); end
    end
    checks++; if (bus.out_data !== 32'h40302010) begin errors++; $display("FAIL relock out_data got %h exp 40302010", bus.out_data); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, dat[i]);
      checks++; if (bus.out_valid !== 4'(1 << i)) begin errors++; $display("FAIL gaps out_valid beat %0d got %b", i, bus.out_valid); end
      checks++; if (bus.frame_done !== (i == 3)) begin errors++; $display("FAIL gaps frame_done beat %0d got %b", i, bus.frame_done); end
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step(1'b0, 1'($urandom), 8'($urandom));
        checks++; if (bus.out_valid !== '0 || bus.frame_done !== 1'b0) begin errors++; $display("FAIL gaps idle strobe got %b/%b exp 0/0", bus.out_valid, bus.frame_done); end
      end
    end
    checks++; if (bus.out_data !== 32'hD3C2B1A0) begin errors++; $display("FAIL gaps out_data got %h exp d3c2b1a0", bus.out_data); end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 1'b1, 8'hE0);
    step(1'b1, 1'b0, 8'hE1);
    #2 rst = 1'b1; model_reset();
    #1;
    checks++; if (bus.out_data !== '0 || bus.out_valid !== '0) begin errors++; $display("FAIL midreset data/strobe got %h/%b exp 0/0", bus.out_data, bus.out_valid); end
    checks++; if (bus.locked !== 1'b0 || bus.frame_done !== 1'b0 || bus.sync_err !== 1'b0) begin errors++; $display("FAIL midreset flags got %b%b%b exp 000", bus.locked, bus.frame_done, bus.sync_err); end
    bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_data = 8'h77;
    @(posedge clk); #1;
    checks++; if (bus.locked !== 1'b0 || bus.out_data !== '0) begin errors++; $display("FAIL midreset held locked/data got %b/%h exp 0/0", bus.locked, bus.out_data); end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'(8'h33 + 8'h11 * i));
      checks++; if (bus.out_valid !== '0 || bus.locked !== 1'b0) begin errors++; $display("FAIL post_reset strobe/locked got %b/%b exp 0/0", bus.out_valid, bus.locked); end
      checks++; if (bus.out_data !== '0 || bus.sync_err !== 1'b0) begin errors++; $display("FAIL post_reset data/err got %h/%b exp 0/0", bus.out_data, bus.sync_err); end
    end
    step(1'b1, 1'b1, 8'h5C);
    checks++; if (bus.locked !== 1'b1 || bus.out_valid !== 4'b0001) begin errors++; $display("FAIL post_reset relock got %b/%b exp 1/0001", bus.locked, bus.out_valid); end
  endtask

  task automatic test_random();
    int pos = 0;
    logic v, s;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0) ? 1'($urandom) : (pos == 0);
      if (v) pos = (pos + 1) % N_CH;
      step(v, s, 8'($urandom));
      checks++; if (bus.out_data !== m_pack()) begin errors++; $display("FAIL random out_data got %h exp %h", bus.out_data, m_pack()); end
      checks++; if (bus.out_valid !== exp_strobe) begin errors++; $display("FAIL random out_valid got %b exp %b", bus.out_valid, exp_strobe); end
      checks++; if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL random frame_done got %b exp %b", bus.frame_done, exp_fd); end
      checks++; if (bus.sync_err !== exp_err) begin errors++; $display("FAIL random sync_err got %b exp %b", bus.sync_err, exp_err); end
      checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL random locked got %b exp %b", bus.locked, m_locked); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    model_reset();
    test_reset();
    test_basic_frame();
    test_hunt_discard();
    test_early_sof();
    test_missing_sof();
    test_gaps();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
